// File: rtl/fabric_config_loader.sv
// Byte-serial, XOR-checked configuration writer for one logic tile LUT/mux and one switch box.
// Commit two edges after the checksum byte; in_ready drops for the single CHECK cycle only.
module fabric_config_loader #(
   parameter int         LUT_WIDTH = 32,
   parameter int         SB_WIDTH  = 16,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 255
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [LUT_WIDTH-1:0] lut_mem,
   output logic                 mux_sel,
   output logic [SB_WIDTH-1:0]  sb_config,
   output logic                 configured,
   output logic                 cfg_done,
   output logic                 cfg_err
);

   localparam int LB = LUT_WIDTH / 8;
   localparam int P  = LB + 1 + SB_WIDTH / 8;
   localparam int CW = $clog2(P + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CTRL_IDX   = CW'(LB);
   localparam logic [CW-1:0] LAST_IDX   = CW'(P - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CSUM, CHECK} state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          count;
   logic [TW-1:0]          timer;
   logic [7:0]             xor_acc;
   logic                   csum_ok;
   logic [LUT_WIDTH-1:0]   lut_sh;
   logic                   mux_sh;
   logic [SB_WIDTH-1:0]    sb_sh;
   logic                   accept;
   logic                   in_frame;
   logic                   timeout_hit;

   assign accept      = in_valid & in_ready;
   assign in_frame    = (state == LOAD) || (state == CSUM);
   // An accepted byte on the would-be expiry cycle takes priority over the timeout.
   assign timeout_hit = in_frame && !accept && (timer == TIMER_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept && in_data == SYNC_BYTE) state_nxt = LOAD;
         LOAD:  if (timeout_hit) state_nxt = IDLE;
                else if (accept && count == LAST_IDX) state_nxt = CSUM;
         CSUM:  if (timeout_hit) state_nxt = IDLE;
                else if (accept) state_nxt = CHECK;
         CHECK: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      if (reset_n && state != CHECK) in_ready = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count      <= '0;
         timer      <= '0;
         xor_acc    <= '0;
         csum_ok    <= 1'b0;
         lut_sh     <= '0;
         mux_sh     <= 1'b0;
         sb_sh      <= '0;
         lut_mem    <= '0;
         mux_sel    <= 1'b0;
         sb_config  <= '0;
         configured <= 1'b0;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && in_data == SYNC_BYTE) begin
                  count   <= '0;
                  xor_acc <= '0;
                  timer   <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  // Bytes arrive MSB first, so each section fills as a left shift.
                  if (count < CTRL_IDX)       lut_sh <= LUT_WIDTH'({lut_sh, in_data});
                  else if (count == CTRL_IDX) mux_sh <= in_data[0];
                  else                        sb_sh  <= SB_WIDTH'({sb_sh, in_data});
                  xor_acc <= xor_acc ^ in_data;
                  count   <= count + CW'(1);
                  timer   <= '0;
               end else begin
                  timer   <= timer + TW'(1);
                  cfg_err <= timeout_hit;
               end
            end
            CSUM: begin
               if (accept) begin
                  csum_ok <= (in_data == xor_acc);
                  timer   <= '0;
               end else begin
                  timer   <= timer + TW'(1);
                  cfg_err <= timeout_hit;
               end
            end
            CHECK: begin
               if (csum_ok) begin
                  lut_mem    <= lut_sh;
                  mux_sel    <= mux_sh;
                  sb_config  <= sb_sh;
                  configured <= 1'b1;
                  cfg_done   <= 1'b1;
               end else begin
                  cfg_err    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
